int_request_gen: RTL and testbench

//   Interrupt source side of the CP0 hardware_interrupt[7:0] bus.

---
 rtl/int_request_gen_if.sv | 24 ++
 rtl/int_request_gen.sv | 111 +++++++++++
 tb/tb_int_request_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/int_request_gen_if.sv
// Register-port and event-line bundle between the interrupt request generator
// and its software/pin side.
`timescale 1ns/1ps
interface int_request_gen_if #(
    parameter int N_SRC = 8
);
    logic [N_SRC-1:0] raw_irq;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [1:0]       rd_addr;
    logic [31:0]      rd_data;
    logic [N_SRC-1:0] hardware_interrupt;

    modport master (
        output raw_irq, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, hardware_interrupt
    );

    modport slave (
        input  raw_irq, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, hardware_interrupt
    );
endinterface

// File: rtl/int_request_gen.sv
// Interrupt source for CP0: synchronises and debounces raw event lines, turns
// qualified rising edges into sticky pending bits, and drives pending & enable.
`timescale 1ns/1ps
module int_request_gen #(
    parameter int N_SRC     = 8,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             clr,
    int_request_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_SWSET   = 2'd2;
    localparam logic [1:0] ADDR_OVERRUN = 2'd3;

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_overrun;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_hw_int;

    logic [N_SRC-1:0] w_hw_set;
    logic [N_SRC-1:0] w_wr_bits;
    logic [N_SRC-1:0] w_clr_mask;
    logic [N_SRC-1:0] w_sw_set;
    logic [N_SRC-1:0] w_ovr_clr;
    logic [N_SRC-1:0] w_pending_next;
    logic [N_SRC-1:0] w_overrun_next;
    logic [N_SRC-1:0] w_enable_next;
    logic             w_unused_wr_bits;

    // Per-source synchroniser and debouncer; hw_set fires on the edge db rises.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            logic             r_s1;
            logic             r_s;
            logic             r_db;
            logic [CNT_W-1:0] r_cnt;
            logic             w_expire;

            assign w_expire     = (r_s != r_db) && (r_cnt == CNT_LAST);
            assign w_hw_set[gi] = w_expire && r_s;

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_s1  <= 1'b0;
                    r_s   <= 1'b0;
                    r_db  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= bus.raw_irq[gi];
                    r_s  <= r_s1;
                    if (r_s == r_db) begin
                        r_cnt <= '0;
                    end else if (w_expire) begin
                        r_db  <= r_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign w_wr_bits        = bus.wr_data[N_SRC-1:0];
    assign w_unused_wr_bits = ^bus.wr_data[31:N_SRC];

    assign w_clr_mask = (bus.wr_en && bus.wr_addr == ADDR_PENDING) ? w_wr_bits : '0;
    assign w_sw_set   = (bus.wr_en && bus.wr_addr == ADDR_SWSET)   ? w_wr_bits : '0;
    assign w_ovr_clr  = (bus.wr_en && bus.wr_addr == ADDR_OVERRUN) ? w_wr_bits : '0;

    // Sets are ORed in after the clear so a same-edge event is never lost.
    assign w_pending_next = (r_pending & ~w_clr_mask) | w_hw_set | w_sw_set;
    assign w_overrun_next = (r_overrun & ~w_ovr_clr)
                          | (w_hw_set & r_pending & ~w_clr_mask);
    assign w_enable_next  = (bus.wr_en && bus.wr_addr == ADDR_ENABLE) ? w_wr_bits : r_enable;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_enable  <= '1;
            r_hw_int  <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
            r_enable  <= w_enable_next;
            r_hw_int  <= w_pending_next & w_enable_next;
        end
    end

    assign bus.hardware_interrupt = r_hw_int;

    always_comb begin
        bus.rd_data = 32'h0;
        case (bus.rd_addr)
            ADDR_PENDING: bus.rd_data = 32'(r_pending);
            ADDR_ENABLE:  bus.rd_data = 32'(r_enable);
            ADDR_SWSET:   bus.rd_data = 32'h0;
            ADDR_OVERRUN: bus.rd_data = 32'(r_overrun);
            default:      bus.rd_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_int_request_gen.sv
// Directed bench for int_request_gen: debounce latency and filtering, W1C vs
// same-edge set, overrun, enable gating and asynchronous reset mid-debounce.
`timescale 1ns/1ps
module tb_int_request_gen;

    logic clk = 1'b0;
    logic clr;

    int_request_gen_if #(.N_SRC(8)) bus ();

    int_request_gen #(
        .N_SRC    (8),
        .DB_CYCLES(4),
        .CNT_W    (3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.rd_addr = addr;
        #0.1;
        check_val(tag, bus.rd_data, exp);
    endtask

    task automatic check_hw(input string tag, input logic [7:0] exp);
        check_val(tag, 32'(bus.hardware_interrupt), 32'(exp));
    endtask

    task automatic reg_wr(input logic [1:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;
        $display("wr addr=%0d data=0x%08h", addr, data);
    endtask

    task automatic pulse(input int idx, input int len);
        bus.raw_irq[idx] = 1'b1;
        repeat (len) tick();
        bus.raw_irq[idx] = 1'b0;
        repeat (12) tick();
        $display("pulse raw_irq[%0d] len=%0d", idx, len);
    endtask

    initial begin
        clr         = 1'b1;
        bus.raw_irq = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'h0;
        bus.rd_addr = 2'd0;
        repeat (2) tick();

        // reset state
        check_hw("rst_hw", 8'h00);
        check_rd("rst_pending", 2'd0, 32'h0);
        check_rd("rst_enable",  2'd1, 32'hFF);
        check_rd("rst_swset",   2'd2, 32'h0);
        check_rd("rst_overrun", 2'd3, 32'h0);
        clr = 1'b0;
        tick();

        // raw_irq[3] rise: visible after edge E0+5
        bus.raw_irq[3] = 1'b1;
        repeat (5) tick();
        check_hw("lat_e4_hw", 8'h00);
        tick();
        check_hw("lat_e5_hw", 8'h08);
        check_rd("lat_pending", 2'd0, 32'h8);
        $display("irq3 qualified");

        // level fall produces nothing and the output holds
        bus.raw_irq[3] = 1'b0;
        repeat (10) tick();
        check_hw("hold_hw", 8'h08);

        // W1C landing on the same edge as a new bit3 event
        bus.raw_irq[3] = 1'b1;
        repeat (5) tick();
        reg_wr(2'd0, 32'h08);
        check_rd("w1c_race_pending", 2'd0, 32'h8);
        check_rd("w1c_race_overrun", 2'd3, 32'h0);
        check_hw("w1c_race_hw", 8'h08);
        reg_wr(2'd0, 32'h08);
        check_rd("w1c_pending", 2'd0, 32'h0);
        check_hw("w1c_hw", 8'h00);
        bus.raw_irq[3] = 1'b0;
        repeat (10) tick();

        // 3-cycle glitch is filtered
        bus.raw_irq[0] = 1'b1;
        repeat (3) tick();
        bus.raw_irq[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_hw($sformatf("glitch3_hw_c%0d", i), 8'h00);
        end
        check_rd("glitch3_pending", 2'd0, 32'h0);
        $display("3-cycle pulse on raw_irq[0] done");

        // exactly DB_CYCLES long is accepted
        pulse(1, 4);
        check_rd("pulse4_pending", 2'd0, 32'h2);
        check_hw("pulse4_hw", 8'h02);
        reg_wr(2'd0, 32'h02);
        check_rd("pulse4_clr", 2'd0, 32'h0);

        // overrun on bit 5
        pulse(5, 6);
        check_rd("ovr_first_pending", 2'd0, 32'h20);
        check_rd("ovr_first_overrun", 2'd3, 32'h0);
        pulse(5, 6);
        check_rd("ovr_second_overrun", 2'd3, 32'h20);
        check_hw("ovr_second_hw", 8'h20);
        reg_wr(2'd3, 32'h20);
        check_rd("ovr_w1c_overrun", 2'd3, 32'h0);
        check_rd("ovr_w1c_pending", 2'd0, 32'h20);
        reg_wr(2'd0, 32'h20);
        check_rd("ovr_pending_clr", 2'd0, 32'h0);

        // enable gating and software set
        reg_wr(2'd1, 32'h00);
        reg_wr(2'd2, 32'h81);
        check_rd("en0_pending", 2'd0, 32'h81);
        check_rd("en0_enable",  2'd1, 32'h0);
        check_rd("en0_swset_rd", 2'd2, 32'h0);
        check_hw("en0_hw", 8'h00);
        reg_wr(2'd1, 32'hFFFF_FFFF);
        check_hw("enff_hw", 8'h81);
        check_rd("enff_enable", 2'd1, 32'hFF);
        reg_wr(2'd0, 32'h81);
        check_hw("enff_clr_hw", 8'h00);

        // async reset while raw_irq[7] is mid-debounce (cnt=2)
        reg_wr(2'd1, 32'h90);
        reg_wr(2'd2, 32'h10);
        check_hw("prerst_hw", 8'h10);
        bus.raw_irq[7] = 1'b1;
        repeat (4) tick();
        #3;
        clr = 1'b1;
        #0.1;
        check_hw("arst_hw", 8'h00);
        check_rd("arst_enable",  2'd1, 32'hFF);
        check_rd("arst_pending", 2'd0, 32'h0);
        $display("async clr asserted mid-debounce");
        repeat (2) tick();
        clr = 1'b0;
        repeat (5) tick();
        check_hw("rearm_e4_hw", 8'h00);
        tick();
        check_hw("rearm_e5_hw", 8'h80);
        check_rd("rearm_pending", 2'd0, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
